truth_table_sweeper: RTL and testbench

- Self-checking stimulus stage wrapped around a small combinational decoder under test (DUT).
- Upstream, it drives every input code in sequence into the DUT.
- Downstream, it samples the DUT's 1-bit output after a settle window and records the result into a truth-table bitmap.
- At the end of the sweep it compares the bitmap against an expected mask and reports pass/fail, the fail count and the first failing code.

---
 rtl/truth_table_sweeper.sv | 144 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps every WIDTH-bit code into a combinational DUT, samples its 1-bit
// response after a settle window and scores the captured truth table.
module truth_table_sweeper #(
   parameter int                        WIDTH         = 3,
   parameter int                        SETTLE_CYCLES = 2,
   parameter logic [(1 << WIDTH) - 1:0] EXPECTED      = 8'b0011_1100
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   output logic [WIDTH-1:0]            code_out,
   input  logic                        dut_in,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic [(1 << WIDTH) - 1:0]   table_out,
   output logic [WIDTH:0]              fail_count,
   output logic [WIDTH-1:0]            first_fail_code,
   output logic                        first_fail_valid
);

   localparam int NCODES = 1 << WIDTH;
   localparam int SW     = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [SW-1:0]    SETTLE_MAX = SW'(SETTLE_CYCLES);
   localparam logic [WIDTH-1:0] CODE_MAX   = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    code_q, code_d;
   logic [SW-1:0]       settle_q, settle_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic [NCODES-1:0]   table_q, table_d;
   logic [WIDTH:0]      fail_q, fail_d;
   logic [WIDTH-1:0]    ffc_q, ffc_d;
   logic                ffv_q, ffv_d;
   logic                mismatch_s;
   logic [WIDTH:0]      fail_next_s;

   // Next-state logic for the sweep FSM and its result registers.
   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      settle_d    = settle_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      table_d     = table_q;
      fail_d      = fail_q;
      ffc_d       = ffc_q;
      ffv_d       = ffv_q;
      mismatch_s  = (dut_in != EXPECTED[code_q]);
      fail_next_s = fail_q + {{WIDTH{1'b0}}, mismatch_s};
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = RUN;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               pass_d   = 1'b0;
               code_d   = {WIDTH{1'b0}};
               settle_d = {SW{1'b0}};
               table_d  = {NCODES{1'b0}};
               fail_d   = {(WIDTH + 1){1'b0}};
               ffv_d    = 1'b0;
               ffc_d    = {WIDTH{1'b0}};
            end else begin
               state_d = state_q;
            end
         end
         RUN: begin
            if (settle_q != SETTLE_MAX) begin
               settle_d = settle_q + {{(SW - 1){1'b0}}, 1'b1};
            end else begin
               // Sample edge: capture, score, then advance or finish.
               table_d[code_q] = dut_in;
               fail_d          = fail_next_s;
               if (mismatch_s && !ffv_q) begin
                  ffc_d = code_q;
                  ffv_d = 1'b1;
               end else begin
                  ffv_d = ffv_q;
               end
               if (code_q == CODE_MAX) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  code_d  = {WIDTH{1'b0}};
                  pass_d  = (fail_next_s == {(WIDTH + 1){1'b0}});
               end else begin
                  code_d   = code_q + {{(WIDTH - 1){1'b0}}, 1'b1};
                  settle_d = {SW{1'b0}};
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         code_q   <= {WIDTH{1'b0}};
         settle_q <= {SW{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         table_q  <= {NCODES{1'b0}};
         fail_q   <= {(WIDTH + 1){1'b0}};
         ffc_q    <= {WIDTH{1'b0}};
         ffv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         settle_q <= settle_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         table_q  <= table_d;
         fail_q   <= fail_d;
         ffc_q    <= ffc_d;
         ffv_q    <= ffv_d;
      end
   end

   assign code_out         = code_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign table_out        = table_q;
   assign fail_count       = fail_q;
   assign first_fail_code  = ffc_q;
   assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: two sweeper instances (default settle and zero settle)
// driving a behavioural decoder that can be good, stuck at 0 or stuck at 1.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, start0;
   int         mode;
   logic       sel;

   logic [2:0] code_a, ffc_a, code_b, ffc_b;
   logic       busy_a, done_a, pass_a, ffv_a, dut_a;
   logic       busy_b, done_b, pass_b, ffv_b, dut_b;
   logic [7:0] table_a, table_b;
   logic [3:0] fail_a, fail_b;

   logic [2:0] cur_code, cur_ffc;
   logic       cur_busy, cur_done, cur_pass, cur_ffv;
   logic [7:0] cur_table;
   logic [3:0] cur_fail;

   typedef struct {
      logic [7:0] tbl;
      logic [3:0] fc;
      logic       ps;
      logic       fv;
      logic [2:0] fcode;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   truth_table_sweeper u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .code_out(code_a), .dut_in(dut_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .table_out(table_a),
      .fail_count(fail_a), .first_fail_code(ffc_a), .first_fail_valid(ffv_a)
   );

   truth_table_sweeper #(.SETTLE_CYCLES(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start0), .code_out(code_b), .dut_in(dut_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .table_out(table_b),
      .fail_count(fail_b), .first_fail_code(ffc_b), .first_fail_valid(ffv_b)
   );

   function automatic logic dut_model(input logic [2:0] c, input int m);
      case (m)
         1:       return 1'b0;
         2:       return 1'b1;
         default: return (c >= 3'd2) && (c <= 3'd5);
      endcase
   endfunction

   always_comb begin
      dut_a = dut_model(code_a, mode);
      dut_b = dut_model(code_b, 0);
   end

   always_comb begin
      cur_code  = sel ? code_b  : code_a;
      cur_ffc   = sel ? ffc_b   : ffc_a;
      cur_busy  = sel ? busy_b  : busy_a;
      cur_done  = sel ? done_b  : done_a;
      cur_pass  = sel ? pass_b  : pass_a;
      cur_ffv   = sel ? ffv_b   : ffv_a;
      cur_table = sel ? table_b : table_a;
      cur_fail  = sel ? fail_b  : fail_a;
   end

   function automatic exp_t predict(input int m);
      exp_t       e;
      logic [7:0] exp_mask;
      logic [7:0] diff;
      exp_mask = 8'h3C;
      e.fc     = 4'd0;
      e.fv     = 1'b0;
      e.fcode  = 3'd0;
      for (int c = 0; c < 8; c++) e.tbl[c] = dut_model(3'(c), m);
      diff = e.tbl ^ exp_mask;
      for (int c = 7; c >= 0; c--) begin
         if (diff[c]) begin
            e.fc    = e.fc + 4'd1;
            e.fv    = 1'b1;
            e.fcode = 3'(c);
         end
      end
      e.ps = (e.fc == 4'd0);
      return e;
   endfunction

   task automatic start_sweep(input logic s, input int m);
      @(negedge clk);
      if (s) start0 = 1'b1;
      else   start  = 1'b1;
      sb.push_back(predict(m));
      @(posedge clk);
      #1;
      start  = 1'b0;
      start0 = 1'b0;
      checks++;
      if ({cur_busy, cur_done, cur_code} !== {1'b1, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL start_edge busy/done/code got %b/%b/%0d want 1/0/0", cur_busy, cur_done, cur_code);
      end
   endtask

   task automatic wait_done(input int hold, input int lat, input bit repulse, input string name);
      int   n = 0;
      exp_t e;
      while (cur_done !== 1'b1 && n < 200) begin
         if (repulse) start = (n == 5 || n == 12);
         @(posedge clk);
         #1;
         n++;
         if (cur_done !== 1'b1) begin
            checks++;
            if (cur_code !== 3'(n / hold) || cur_busy !== 1'b1) begin
               errors++;
               $display("FAIL %s code_step edge %0d code %0d busy %b want %0d 1", name, n, cur_code, cur_busy, n / hold);
            end
         end
      end
      start = 1'b0;
      checks++;
      if (n != lat) begin
         errors++;
         $display("FAIL %s latency got %0d want %0d", name, n, lat);
      end
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         if (cur_table !== e.tbl || cur_fail !== e.fc || cur_pass !== e.ps ||
             cur_ffv !== e.fv || cur_ffc !== e.fcode || cur_busy !== 1'b0 || cur_code !== 3'd0) begin
            errors++;
            $display("FAIL %s result table %h fc %0d pass %b ffv %b ffc %0d busy %b code %0d want %h %0d %b %b %0d 0 0",
                     name, cur_table, cur_fail, cur_pass, cur_ffv, cur_ffc, cur_busy, cur_code,
                     e.tbl, e.fc, e.ps, e.fv, e.fcode);
         end
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({code_a, busy_a, done_a, pass_a, table_a, fail_a, ffc_a, ffv_a} !== 22'd0 ||
          {code_b, busy_b, done_b, pass_b, table_b, fail_b, ffc_b, ffv_b} !== 22'd0) begin
         errors++;
         $display("FAIL %s outputs a=%h/%b%b%b/%h/%0d/%0d/%b b=%h/%b%b%b/%h/%0d/%0d/%b want all 0", name,
                  code_a, busy_a, done_a, pass_a, table_a, fail_a, ffc_a, ffv_a,
                  code_b, busy_b, done_b, pass_b, table_b, fail_b, ffc_b, ffv_b);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; start0 = 1'b1; mode = 0; sel = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1; start = 1'b0; start0 = 1'b0;
   endtask

   task automatic test_good();
      sel = 1'b0; mode = 0;
      start_sweep(1'b0, 0);
      wait_done(3, 24, 1'b0, "good");
   endtask

   task automatic test_stuck(input int m, input string name);
      sel = 1'b0; mode = m;
      start_sweep(1'b0, m);
      wait_done(3, 24, 1'b0, name);
   endtask

   task automatic test_repulse();
      sel = 1'b0; mode = 0;
      start_sweep(1'b0, 0);
      wait_done(3, 24, 1'b1, "repulse");
   endtask

   task automatic test_mid_reset();
      sel = 1'b0; mode = 0;
      start_sweep(1'b0, 0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      check_zero("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({busy_a, done_a, code_a, table_a} !== 13'd0) begin
         errors++;
         $display("FAIL mid_reset_idle busy %b done %b code %0d table %h want 0", busy_a, done_a, code_a, table_a);
      end
      test_good();
   endtask

   task automatic test_settle0_restart();
      sel = 1'b1;
      start_sweep(1'b1, 0);
      wait_done(1, 8, 1'b0, "settle0");
      @(negedge clk);
      start0 = 1'b1;
      sb.push_back(predict(0));
      @(posedge clk);
      #1;
      start0 = 1'b0;
      checks++;
      if ({busy_b, done_b, pass_b, table_b, fail_b, ffv_b} !== {1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL restart_clear busy %b done %b pass %b table %h fc %0d ffv %b want 1 0 0 00 0 0",
                  busy_b, done_b, pass_b, table_b, fail_b, ffv_b);
      end
      wait_done(1, 8, 1'b0, "restart");
   endtask

   initial begin
      test_reset();
      test_good();
      test_stuck(1, "stuck0");
      test_stuck(2, "stuck1");
      test_repulse();
      test_mid_reset();
      test_settle0_restart();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
